// File: rtl/l1_refill_controller_pkg.sv
// Shared types and constants for the L1 line-refill engine.
// The burst always carries eight words, so word indices are 3 bits wide.
package l1_refill_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ADDR,
        DATA,
        DONE
    } refill_state_t;

    localparam logic [3:0]  ACK_NONE  = 4'b1111;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF8;
    localparam logic [2:0]  LAST_IDX  = 3'd7;

    // Word-acknowledge encoding on the 4-bit ACK buses.
    function automatic logic [3:0] ack_code(input logic [2:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/l1_refill_controller_timeout_ctr.sv
// Saturating stall counter.
// expire is raised on the count at which the next increment would reach LIMIT.
module refill_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int           CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] SAT   = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    // Depends only on the registered count, so it can steer the FSM without a loop.
    assign expire = inc && (count == LAST);

endmodule

// File: rtl/l1_refill_controller.sv
// L1-side miss/refill engine: runs the memory LOAD handshake and streams
// the eight-word burst into the L1 data array.
//
// state    | meaning
// IDLE     | waiting for a miss request
// WAIT_RDY | VALID/LOAD raised, waiting for memory READY
// ADDR     | line address on the bus with ACK_ADDR, waiting for word 0
// DATA     | capturing words 0..7 in order
// DONE     | last word acknowledged, waiting for memory to drop READY
module l1_refill_controller
    import l1_refill_controller_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    output logic              REQ_READY,
    output logic              MEM_VALID,
    output logic              MEM_LOAD,
    output logic              MEM_STORE,
    input  logic              MEM_READY,
    output logic [ADDR_W-1:0] MEM_DATA_OUT,
    output logic              MEM_DATA_OE,
    input  logic [ADDR_W-1:0] MEM_DATA_IN,
    output logic              ACK_ADDR,
    output logic [3:0]        ACK_DATA_L1,
    input  logic [3:0]        ACK_DATA_MEM,
    output logic              FILL_WE,
    output logic [2:0]        FILL_IDX,
    output logic [ADDR_W-1:0] FILL_DATA,
    output logic [ADDR_W-1:0] FILL_LINE_ADDR,
    output logic              FILL_DONE,
    output logic              FILL_ERR
);

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_LINE - 1);

    refill_state_t state, state_n;

    logic              req_ready,   req_ready_n;
    logic              mem_valid,   mem_valid_n;
    logic              mem_load,    mem_load_n;
    logic              mem_data_oe, mem_data_oe_n;
    logic              ack_addr,    ack_addr_n;
    logic [3:0]        ack_l1,      ack_l1_n;
    logic              fill_we,     fill_we_n;
    logic [2:0]        fill_idx,    fill_idx_n;
    logic [ADDR_W-1:0] fill_data,   fill_data_n;
    logic [ADDR_W-1:0] line_addr,   line_addr_n;
    logic              fill_done,   fill_done_n;
    logic              fill_err,    fill_err_n;
    logic [2:0]        exp_idx,     exp_idx_n;

    logic capture;
    logic abort;
    logic tmo_clr;
    logic tmo_inc;
    logic tmo_expire;

    refill_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );

    always_comb begin
        state_n       = state;
        req_ready_n   = req_ready;
        mem_valid_n   = mem_valid;
        mem_load_n    = mem_load;
        mem_data_oe_n = mem_data_oe;
        ack_addr_n    = ack_addr;
        ack_l1_n      = ack_l1;
        fill_we_n     = 1'b0;
        fill_idx_n    = fill_idx;
        fill_data_n   = fill_data;
        line_addr_n   = line_addr;
        fill_done_n   = 1'b0;
        fill_err_n    = 1'b0;
        exp_idx_n     = exp_idx;
        capture       = 1'b0;
        abort         = 1'b0;

        case (state)
            IDLE: begin
                // Ready rises one cycle after returning here, so a request
                // held through a fill is only taken once the handshake shows it.
                req_ready_n = 1'b1;
                if (req_ready && REQ_VALID) begin
                    line_addr_n = REQ_ADDR & LINE_MASK[ADDR_W-1:0];
                    req_ready_n = 1'b0;
                    mem_valid_n = 1'b1;
                    mem_load_n  = 1'b1;
                    state_n     = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (MEM_READY) begin
                    mem_data_oe_n = 1'b1;
                    ack_addr_n    = 1'b1;
                    state_n       = ADDR;
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end
            end
            ADDR: begin
                if (ACK_DATA_MEM == ack_code(3'd0)) begin
                    mem_data_oe_n = 1'b0;
                    ack_addr_n    = 1'b0;
                    exp_idx_n     = 3'd0;
                    state_n       = DATA;
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end
            end
            DATA: begin
                // Only the next expected index fires, so a stale or repeated
                // index from memory never writes the array twice.
                if (ACK_DATA_MEM == ack_code(exp_idx)) begin
                    capture     = 1'b1;
                    fill_we_n   = 1'b1;
                    fill_idx_n  = exp_idx;
                    fill_data_n = MEM_DATA_IN;
                    ack_l1_n    = ack_code(exp_idx);
                    if (exp_idx == LAST_WORD) begin
                        state_n = DONE;
                    end else begin
                        exp_idx_n = exp_idx + 1'b1;
                    end
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                ack_l1_n = ack_code(LAST_IDX);
                if (!MEM_READY) begin
                    mem_valid_n = 1'b0;
                    mem_load_n  = 1'b0;
                    ack_l1_n    = ACK_NONE;
                    fill_done_n = 1'b1;
                    state_n     = IDLE;
                end else if (tmo_expire) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (abort) begin
            state_n       = IDLE;
            fill_err_n    = 1'b1;
            mem_valid_n   = 1'b0;
            mem_load_n    = 1'b0;
            mem_data_oe_n = 1'b0;
            ack_addr_n    = 1'b0;
            ack_l1_n      = ACK_NONE;
        end
    end

    assign tmo_clr = (state_n != state) || capture;
    assign tmo_inc = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            mem_valid   <= 1'b0;
            mem_load    <= 1'b0;
            mem_data_oe <= 1'b0;
            ack_addr    <= 1'b0;
            ack_l1      <= ACK_NONE;
            fill_we     <= 1'b0;
            fill_idx    <= 3'd0;
            fill_data   <= '0;
            line_addr   <= '0;
            fill_done   <= 1'b0;
            fill_err    <= 1'b0;
            exp_idx     <= 3'd0;
        end else begin
            state       <= state_n;
            req_ready   <= req_ready_n;
            mem_valid   <= mem_valid_n;
            mem_load    <= mem_load_n;
            mem_data_oe <= mem_data_oe_n;
            ack_addr    <= ack_addr_n;
            ack_l1      <= ack_l1_n;
            fill_we     <= fill_we_n;
            fill_idx    <= fill_idx_n;
            fill_data   <= fill_data_n;
            line_addr   <= line_addr_n;
            fill_done   <= fill_done_n;
            fill_err    <= fill_err_n;
            exp_idx     <= exp_idx_n;
        end
    end

    assign REQ_READY      = req_ready;
    assign MEM_VALID      = mem_valid;
    assign MEM_LOAD       = mem_load;
    assign MEM_STORE      = 1'b0;
    assign MEM_DATA_OE    = mem_data_oe;
    assign MEM_DATA_OUT   = mem_data_oe ? line_addr : '0;
    assign ACK_ADDR       = ack_addr;
    assign ACK_DATA_L1    = ack_l1;
    assign FILL_WE        = fill_we;
    assign FILL_IDX       = fill_idx;
    assign FILL_DATA      = fill_data;
    assign FILL_LINE_ADDR = line_addr;
    assign FILL_DONE      = fill_done;
    assign FILL_ERR       = fill_err;

endmodule

// File: tb/tb_l1_refill_controller.sv
// Directed bench for l1_refill_controller with a handshake-driven memory model.
module tb_l1_refill_controller;

    localparam int TMO = 255;
    localparam int BUDGET = 200;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic [31:0] REQ_ADDR;
    logic        REQ_READY;
    logic        MEM_VALID;
    logic        MEM_LOAD;
    logic        MEM_STORE;
    logic        MEM_READY;
    logic [31:0] MEM_DATA_OUT;
    logic        MEM_DATA_OE;
    logic [31:0] MEM_DATA_IN;
    logic        ACK_ADDR;
    logic [3:0]  ACK_DATA_L1;
    logic [3:0]  ACK_DATA_MEM;
    logic        FILL_WE;
    logic [2:0]  FILL_IDX;
    logic [31:0] FILL_DATA;
    logic [31:0] FILL_LINE_ADDR;
    logic        FILL_DONE;
    logic        FILL_ERR;

    int n_tests = 0;
    int n_fail  = 0;
    int wait_tmo = 0;

    logic [2:0]  we_idx[$];
    logic [31:0] we_data[$];
    logic [3:0]  ack_trace[$];
    logic [3:0]  ack_prev = 4'hF;
    int done_cnt = 0;
    int err_cnt  = 0;
    int oe_bad   = 0;

    logic [31:0] addr_seen;
    logic        oe_seen;

    l1_refill_controller #(
        .WORDS_PER_LINE (8),
        .ADDR_W         (32),
        .TIMEOUT        (TMO)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .REQ_VALID      (REQ_VALID),
        .REQ_ADDR       (REQ_ADDR),
        .REQ_READY      (REQ_READY),
        .MEM_VALID      (MEM_VALID),
        .MEM_LOAD       (MEM_LOAD),
        .MEM_STORE      (MEM_STORE),
        .MEM_READY      (MEM_READY),
        .MEM_DATA_OUT   (MEM_DATA_OUT),
        .MEM_DATA_OE    (MEM_DATA_OE),
        .MEM_DATA_IN    (MEM_DATA_IN),
        .ACK_ADDR       (ACK_ADDR),
        .ACK_DATA_L1    (ACK_DATA_L1),
        .ACK_DATA_MEM   (ACK_DATA_MEM),
        .FILL_WE        (FILL_WE),
        .FILL_IDX       (FILL_IDX),
        .FILL_DATA      (FILL_DATA),
        .FILL_LINE_ADDR (FILL_LINE_ADDR),
        .FILL_DONE      (FILL_DONE),
        .FILL_ERR       (FILL_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FILL_WE) begin
            we_idx.push_back(FILL_IDX);
            we_data.push_back(FILL_DATA);
        end
        if (FILL_DONE) done_cnt++;
        if (FILL_ERR) err_cnt++;
        if (MEM_DATA_OE && !ACK_ADDR) oe_bad++;
        if (ACK_DATA_L1 !== ack_prev) begin
            ack_trace.push_back(ACK_DATA_L1);
            ack_prev = ACK_DATA_L1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for REQ_READY, then presents one request for a single accepting edge.
    task automatic request(input logic [31:0] addr);
        int guard;
        guard = 0;
        while (!REQ_READY && guard < BUDGET) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= BUDGET) wait_tmo++;
        REQ_ADDR  = addr;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    // Memory side: READY after rdy_dly, then presents words one at a time, each
    // after word_dly cycles of still showing the previous index.
    task automatic mem_serve(input int rdy_dly, input int word_dly, input int n_words,
                             input logic [31:0] base);
        int guard;
        guard = 0;
        while (!MEM_VALID && guard < BUDGET) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= BUDGET) wait_tmo++;
        repeat (rdy_dly) @(negedge CLK);
        MEM_READY = 1'b1;
        guard = 0;
        while (!ACK_ADDR && guard < BUDGET) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= BUDGET) wait_tmo++;
        addr_seen = MEM_DATA_OUT;
        oe_seen   = MEM_DATA_OE;
        for (int i = 0; i < n_words; i++) begin
            repeat (word_dly) @(negedge CLK);
            ACK_DATA_MEM = 4'(i);
            MEM_DATA_IN  = base + 32'(i);
            guard = 0;
            while (ACK_DATA_L1 !== 4'(i) && guard < BUDGET) begin
                @(negedge CLK);
                guard++;
            end
            if (guard >= BUDGET) wait_tmo++;
        end
        if (n_words == 8) begin
            ACK_DATA_MEM = 4'hF;
            MEM_READY    = 1'b0;
            guard = 0;
            while (MEM_VALID && guard < BUDGET) begin
                @(negedge CLK);
                guard++;
            end
            if (guard >= BUDGET) wait_tmo++;
        end
    endtask

    task automatic check_fill(input string tag, input int we_base, input int ack_base,
                              input logic [31:0] base);
        chk($sformatf("%s_we_count", tag), 32'(we_idx.size() - we_base), 32'd8);
        for (int i = 0; i < 8 && we_base + i < we_idx.size(); i++) begin
            chk($sformatf("%s_idx%0d", tag, i), 32'(we_idx[we_base + i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), we_data[we_base + i], base + 32'(i));
        end
        chk($sformatf("%s_ack_count", tag), 32'(ack_trace.size() - ack_base), 32'd9);
        for (int i = 0; i < 9 && ack_base + i < ack_trace.size(); i++) begin
            chk($sformatf("%s_ack%0d", tag, i), 32'(ack_trace[ack_base + i]),
                (i == 8) ? 32'hF : 32'(i));
        end
    endtask

    initial begin
        int wb, ab, db, eb;

        RST          = 1'b1;
        REQ_VALID    = 1'b0;
        REQ_ADDR     = 32'h0;
        MEM_READY    = 1'b0;
        MEM_DATA_IN  = 32'h0;
        ACK_DATA_MEM = 4'hF;
        @(negedge CLK);
        chk("rst_req_ready", 32'(REQ_READY), 32'd1);
        chk("rst_mem_valid", 32'(MEM_VALID), 32'd0);
        chk("rst_mem_load", 32'(MEM_LOAD), 32'd0);
        chk("rst_mem_store", 32'(MEM_STORE), 32'd0);
        chk("rst_oe", 32'(MEM_DATA_OE), 32'd0);
        chk("rst_ack_addr", 32'(ACK_ADDR), 32'd0);
        chk("rst_ack_l1", 32'(ACK_DATA_L1), 32'hF);
        chk("rst_fill_we", 32'(FILL_WE), 32'd0);
        chk("rst_fill_idx", 32'(FILL_IDX), 32'd0);
        chk("rst_fill_data", FILL_DATA, 32'd0);
        chk("rst_line", FILL_LINE_ADDR, 32'd0);
        chk("rst_done_err", {30'd0, FILL_DONE, FILL_ERR}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Basic fill, zero-wait memory
        wb = we_idx.size(); ab = ack_trace.size(); db = done_cnt;
        request(32'h0000_0013);
        chk("basic_accept_valid", {30'd0, MEM_VALID, MEM_LOAD}, 32'd3);
        chk("basic_accept_ready", 32'(REQ_READY), 32'd0);
        chk("basic_line_latched", FILL_LINE_ADDR, 32'h0000_0010);
        mem_serve(0, 0, 8, 32'hA000_0000);
        chk("basic_addr_phase", addr_seen, 32'h0000_0010);
        chk("basic_addr_oe", 32'(oe_seen), 32'd1);
        chk("basic_done_pulse", 32'(FILL_DONE), 32'd1);
        chk("basic_ready_on_done", 32'(REQ_READY), 32'd0);
        chk("basic_line_held", FILL_LINE_ADDR, 32'h0000_0010);
        @(negedge CLK);
        chk("basic_ready_after", 32'(REQ_READY), 32'd1);
        chk("basic_done_cleared", 32'(FILL_DONE), 32'd0);
        chk("basic_done_count", 32'(done_cnt - db), 32'd1);
        check_fill("basic", wb, ab, 32'hA000_0000);

        // Slow memory: READY after 5 cycles, 3 stale cycles before each word
        wb = we_idx.size(); ab = ack_trace.size(); db = done_cnt;
        request(32'h0000_123C);
        mem_serve(5, 3, 8, 32'hB000_0000);
        chk("slow_addr_phase", addr_seen, 32'h0000_1238);
        @(negedge CLK);
        chk("slow_done_count", 32'(done_cnt - db), 32'd1);
        check_fill("slow", wb, ab, 32'hB000_0000);

        // Back-to-back: second request held high throughout the first fill
        wb = we_idx.size(); ab = ack_trace.size(); db = done_cnt;
        REQ_ADDR  = 32'h0000_2004;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_ADDR = 32'h0000_3007;
        chk("b2b_first_line", FILL_LINE_ADDR, 32'h0000_2000);
        mem_serve(1, 1, 8, 32'hC000_0000);
        chk("b2b_line_held", FILL_LINE_ADDR, 32'h0000_2000);
        chk("b2b_not_ready_on_done", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        chk("b2b_ready_then", 32'(REQ_READY), 32'd1);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("b2b_second_valid", 32'(MEM_VALID), 32'd1);
        chk("b2b_second_line", FILL_LINE_ADDR, 32'h0000_3000);
        check_fill("b2b_first", wb, ab, 32'hC000_0000);
        wb = we_idx.size(); ab = ack_trace.size();
        mem_serve(0, 0, 8, 32'hD000_0000);
        chk("b2b_second_addr", addr_seen, 32'h0000_3000);
        @(negedge CLK);
        chk("b2b_done_count", 32'(done_cnt - db), 32'd2);
        check_fill("b2b_second", wb, ab, 32'hD000_0000);

        // Timeout: memory never raises READY
        db = done_cnt; eb = err_cnt;
        request(32'h0000_4000);
        repeat (TMO - 1) @(negedge CLK);
        chk("tmo_no_err_early", 32'(FILL_ERR), 32'd0);
        chk("tmo_valid_before", 32'(MEM_VALID), 32'd1);
        @(negedge CLK);
        chk("tmo_err_pulse", 32'(FILL_ERR), 32'd1);
        chk("tmo_mem_released", {30'd0, MEM_VALID, MEM_LOAD}, 32'd0);
        chk("tmo_ack_none", 32'(ACK_DATA_L1), 32'hF);
        @(negedge CLK);
        chk("tmo_err_cleared", 32'(FILL_ERR), 32'd0);
        chk("tmo_ready_next", 32'(REQ_READY), 32'd1);
        chk("tmo_err_count", 32'(err_cnt - eb), 32'd1);
        chk("tmo_no_done", 32'(done_cnt - db), 32'd0);

        // Reset after word 3, then a normal fill
        db = done_cnt; eb = err_cnt;
        request(32'h0000_5017);
        mem_serve(0, 0, 4, 32'hE000_0000);
        chk("rmid_word3", 32'(ACK_DATA_L1), 32'd3);
        RST = 1'b1;
        #1;
        chk("rmid_req_ready", 32'(REQ_READY), 32'd1);
        chk("rmid_mem_valid", {30'd0, MEM_VALID, MEM_LOAD}, 32'd0);
        chk("rmid_ack_l1", 32'(ACK_DATA_L1), 32'hF);
        chk("rmid_fill_idx", 32'(FILL_IDX), 32'd0);
        chk("rmid_fill_data", FILL_DATA, 32'd0);
        chk("rmid_line", FILL_LINE_ADDR, 32'd0);
        MEM_READY    = 1'b0;
        ACK_DATA_MEM = 4'hF;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rmid_no_done_err", 32'((done_cnt - db) + (err_cnt - eb)), 32'd0);
        wb = we_idx.size(); ab = ack_trace.size();
        request(32'h0000_602F);
        mem_serve(0, 2, 8, 32'hF000_0000);
        chk("post_addr_phase", addr_seen, 32'h0000_6028);
        @(negedge CLK);
        chk("post_done_count", 32'(done_cnt - db), 32'd1);
        check_fill("post", wb, ab, 32'hF000_0000);

        chk("oe_outside_addr", 32'(oe_bad), 32'd0);
        chk("wait_budget", 32'(wait_tmo), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
